// File: rtl/move_sequencer.sv
// Timed command sequencer: queues (code, duration) entries and plays them onto
// movementCommand, inserting a Stop gap before any change of motion direction.
module move_sequencer #(
  parameter int DEPTH    = 4,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 100000,
  parameter int GAP_MS   = 50
) (
  input  logic                     CLK100MHZ,
  input  logic                     CPU_RESETN,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_code,
  input  logic [DUR_W-1:0]         cmd_dur,
  input  logic                     abort,
  output logic [2:0]               movementCommand,
  output logic                     busy,
  output logic                     done,
  output logic                     bad_cmd,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(GAP_MS + 1);
  localparam int CW = (DUR_W > GW) ? DUR_W : GW;
  localparam logic [2:0] C_STOP = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_RUN} state_t;

  logic [2:0]       code_mem_q [DEPTH];
  logic [DUR_W-1:0] dur_mem_q  [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;

  state_t           state_q;
  logic [2:0]       mc_q, last_q, pend_code_q;
  logic [DUR_W-1:0] pend_dur_q;
  logic [PW-1:0]    presc_q;
  logic [CW-1:0]    tmr_q;
  logic             busy_q, done_q, bad_q;

  logic             full, push, pop, tick, expire;
  logic [2:0]       head_code;
  logic [DUR_W-1:0] head_dur;

  state_t           ev_state;
  logic [2:0]       ev_mc, ev_last;
  logic             ev_busy, ev_bad;
  logic [CW-1:0]    ev_tmr;

  assign full       = (cnt_q == (AW+1)'(DEPTH));
  assign cmd_ready  = !full && !abort;
  assign push       = cmd_valid && cmd_ready;
  assign tick       = (presc_q == PW'(TICK_DIV - 1));
  assign expire     = tick && (tmr_q == CW'(1));
  assign pop        = !abort && (cnt_q != '0) &&
                      ((state_q == S_IDLE) || ((state_q == S_RUN) && expire));
  assign head_code  = code_mem_q[rptr_q];
  assign head_dur   = dur_mem_q[rptr_q];

  assign movementCommand = mc_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign bad_cmd         = bad_q;
  assign fifo_count      = cnt_q;

  always_ff @(posedge CLK100MHZ) begin
    if (push) begin
      code_mem_q[wptr_q] <= cmd_code;
      dur_mem_q[wptr_q]  <= cmd_dur;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (abort) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Motion codes (000/001/100/101) are exactly those with bit 1 clear.
  always_comb begin
    ev_state = S_IDLE;
    ev_mc    = C_STOP;
    ev_busy  = 1'b0;
    ev_bad   = 1'b0;
    ev_tmr   = CW'(head_dur);
    ev_last  = last_q;
    if (head_code[2:1] == 2'b11) begin
      ev_bad = 1'b1;
    end else if (head_dur != '0) begin
      ev_busy = 1'b1;
      if ((GAP_MS > 0) && !last_q[1] && (head_code != last_q)) begin
        ev_state = S_GAP;
        ev_tmr   = CW'(GAP_MS);
      end else begin
        ev_state = S_RUN;
        ev_mc    = head_code;
        ev_last  = head_code[1] ? C_STOP : head_code;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q     <= S_IDLE;
      mc_q        <= C_STOP;
      last_q      <= C_STOP;
      pend_code_q <= C_STOP;
      pend_dur_q  <= '0;
      presc_q     <= '0;
      tmr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      mc_q    <= C_STOP;
      last_q  <= C_STOP;
      presc_q <= '0;
      tmr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (pop) begin
        // Covers both IDLE pops and back-to-back chaining at RUN expiry.
        state_q     <= ev_state;
        mc_q        <= ev_mc;
        busy_q      <= ev_busy;
        bad_q       <= ev_bad;
        tmr_q       <= ev_tmr;
        last_q      <= ev_last;
        presc_q     <= '0;
        pend_code_q <= head_code;
        pend_dur_q  <= head_dur;
      end else begin
        case (state_q)
          S_IDLE: presc_q <= '0;
          S_GAP: if (tick) begin
            if (tmr_q == CW'(1)) begin
              state_q <= S_RUN;
              mc_q    <= pend_code_q;
              tmr_q   <= CW'(pend_dur_q);
              last_q  <= pend_code_q[1] ? C_STOP : pend_code_q;
            end else begin
              tmr_q <= tmr_q - CW'(1);
            end
          end
          S_RUN: if (tick) begin
            if (tmr_q == CW'(1)) begin
              state_q <= S_IDLE;
              mc_q    <= C_STOP;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              tmr_q <= tmr_q - CW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed scenarios plus random traffic, all checked
// against a cycle-count model built from queues and remaining-cycle budgets.
module tb_move_sequencer;
  localparam int DEPTH = 4, DUR_W = 4, TD = 4, GAP = 2;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             vld = 1'b0, ab = 1'b0;
  logic [2:0]       code = 3'd0;
  logic [DUR_W-1:0] dur = '0;
  logic             ready, busy, done, bad_cmd;
  logic [2:0]       mc;
  logic [2:0]       fcnt;

  move_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_DIV(TD), .GAP_MS(GAP)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .cmd_valid(vld), .cmd_ready(ready),
    .cmd_code(code), .cmd_dur(dur), .abort(ab), .movementCommand(mc),
    .busy(busy), .done(done), .bad_cmd(bad_cmd), .fifo_count(fcnt));

  always #5 clk = ~clk;

  typedef struct {int code; int dur;} ent_t;
  ent_t mq[$];
  ent_t m_pend;
  int   m_mode, m_left, m_mc, m_last, m_busy, m_done, m_bad;
  int   n_tot = 0, n_bad = 0, n_done = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  function automatic bit is_mot(input int c);
    return (c == 0) || (c == 1) || (c == 4) || (c == 5);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_mode = 0; m_left = 0; m_mc = 2; m_last = 2;
    m_busy = 0; m_done = 0; m_bad = 0;
  endtask

  task automatic m_idle();
    m_mode = 0; m_mc = 2; m_busy = 0;
  endtask

  task automatic m_run(input ent_t e);
    m_mode = 2; m_left = e.dur * TD; m_mc = e.code; m_busy = 1;
    m_last = is_mot(e.code) ? e.code : 2;
  endtask

  task automatic m_eval(input ent_t e);
    if (e.code >= 6) begin
      m_bad = 1; m_idle();
    end else if (e.dur == 0) begin
      m_idle();
    end else if (is_mot(m_last) && e.code != m_last) begin
      m_mode = 1; m_left = GAP * TD; m_mc = 2; m_busy = 1; m_pend = e;
    end else begin
      m_run(e);
    end
  endtask

  // One rising edge of the reference behaviour, using the inputs now applied.
  task automatic m_step();
    bit   acc;
    ent_t e;
    acc = vld && (mq.size() < DEPTH) && !ab;
    m_done = 0; m_bad = 0;
    if (ab) begin
      mq.delete(); m_idle(); m_last = 2;
    end else begin
      case (m_mode)
        0: if (mq.size() > 0) m_eval(mq.pop_front());
        1: begin m_left--; if (m_left == 0) m_run(m_pend); end
        default: begin
          m_left--;
          if (m_left == 0) begin
            if (mq.size() > 0) m_eval(mq.pop_front());
            else begin m_idle(); m_done = 1; end
          end
        end
      endcase
      if (acc) begin e.code = int'(code); e.dur = int'(dur); mq.push_back(e); end
    end
  endtask

  task automatic check_all();
    chk("mc", int'(mc), m_mc);
    chk("busy", int'(busy), m_busy);
    chk("done", int'(done), m_done);
    chk("bad_cmd", int'(bad_cmd), m_bad);
    chk("fifo_count", int'(fcnt), mq.size());
    chk("cmd_ready", int'(ready), int'(mq.size() < DEPTH && !ab));
    n_done += int'(done);
  endtask

  task automatic cyc(input bit v, input int c, input int d, input bit a);
    vld = v; code = 3'(c); dur = DUR_W'(d); ab = a;
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    int d0;
    m_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    d0 = n_done;
    cyc(1, 0, 3, 0); idle(20);
    chk("done_single", n_done - d0, 1);

    cyc(1, 0, 2, 0); cyc(1, 1, 2, 0); idle(34);

    d0 = n_done;
    cyc(1, 4, 1, 0); cyc(1, 4, 1, 0); idle(24);
    chk("done_chain", n_done - d0, 1);

    cyc(1, 0, 15, 0);
    for (int i = 0; i < 8; i++) cyc(1, 5, 1, 0);
    chk("full_count", int'(fcnt), DEPTH);
    idle(130);

    cyc(0, 0, 0, 1);
    cyc(1, 7, 5, 0); cyc(1, 2, 0, 0); cyc(1, 5, 1, 0); idle(12);

    d0 = n_done;
    cyc(1, 0, 10, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); idle(6);
    cyc(1, 4, 1, 1);
    chk("abort_nodone", n_done - d0, 0);
    cyc(1, 1, 1, 0); idle(8);
    cyc(1, 0, 5, 0); cyc(1, 1, 2, 0); idle(5);

    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_mc", int'(mc), 2);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(fcnt), 0);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      int c, d;
      c = ($urandom % 6 == 0) ? 6 + int'($urandom % 2) : int'($urandom % 6);
      d = ($urandom % 10 == 0) ? 15 : int'($urandom % 4);
      cyc(($urandom % 3) != 0, c, d, ($urandom % 80) == 0);
    end
    idle(150);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Timed command sequencer that drives the 3-bit movementCommand input of the motor direction decoder.
- Upstream logic (search/sort FSM) pushes (command, duration-in-ms) entries into a small internal FIFO.
- The block executes entries back-to-back, each for exactly its duration.
- It inserts a mandatory Stop gap before any change of motion direction, and supports an immediate abort, e.g. from the obstacle sensor.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
DUR_W, 16, width of duration field in ms ticks
TICK_DIV, 100000, clock cycles per ms tick (100 MHz)
GAP_MS, 50, Stop gap length in ticks, inserted between differing motion commands

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
CPU_RESETN  in  1  asynchronous active-low reset
cmd_valid  in  1  entry offered
cmd_ready  out  1  entry accepted when cmd_valid && cmd_ready at rising edge
cmd_code  in  3  000 fwd, 001 back, 010 stop, 011 coast, 100 left, 101 right
cmd_dur  in  DUR_W  duration in ms ticks
abort  in  1  level; flush and stop
movementCommand  out  3  to direction decoder
busy  out  1  high in GAP or RUN
done  out  1  one-cycle pulse when last queued entry finishes (not on abort)
bad_cmd  out  1  one-cycle pulse when a 110/111 entry is popped
fifo_count  out  $clog2(DEPTH)+1  entries queued

Behaviour:
- Reset (async, CPU_RESETN low):
  - FIFO empty; state IDLE; movementCommand=010; busy=0, done=0, bad_cmd=0, fifo_count=0.
  - last_motion=010; prescaler and duration counter cleared.
- Handshake:
  - cmd_ready = !full && !abort.
  - A push on a full FIFO is not possible; a pop in the same cycle does not free space until the next cycle.
  - Push and pop in the same cycle with the FIFO non-full: both occur, count unchanged.
- Tick:
  - Prescaler counts 0..TICK_DIV-1 and restarts at 0 on every state entry.
  - A tick is asserted when the prescaler reaches TICK_DIV-1.
  - As a result, a duration of D lasts exactly D*TICK_DIV cycles.
- States IDLE, GAP, RUN. All outputs are registered.
- IDLE:
  - movementCommand=010.
  - If FIFO is non-empty, pop the head and evaluate it (evaluation rules below).
- Pop evaluation (IDLE, or end of RUN):
  - code 110/111: pulse bad_cmd, discard, evaluate the next entry in the following cycle.
  - dur==0: discard silently.
  - Otherwise, need_gap = last_motion is a motion code (000/001/100/101) and cmd_code != last_motion.
    - need_gap: enter GAP with movementCommand=010 for GAP_MS ticks.
    - Else enter RUN directly.
  - movementCommand takes the new value in the cycle after the pop.
- GAP:
  - Hold 010.
  - After GAP_MS ticks, enter RUN with the pending entry; movementCommand updates on the same edge.
- RUN:
  - Hold cmd_code for dur ticks; last_motion <= cmd_code on entry.
  - For 010/011 entries, last_motion becomes 010 (non-motion), so no gap follows.
  - At expiry:
    - FIFO non-empty: pop and evaluate in the same cycle. There is no Stop cycle between identical codes.
    - FIFO empty: go to IDLE (movementCommand=010 next cycle), pulse done, last_motion unchanged.
- Repeated identical codes chain seamlessly. Example: fwd then fwd produces one continuous 000 span.
- abort high (any state):
  - Next edge: FIFO flushed, state IDLE, movementCommand=010, last_motion=010, no done pulse.
  - Pushes are blocked while abort is high.
- Duration counter width is DUR_W. The maximum value (2^DUR_W - 1) must not wrap.
- Mid-operation reset behaves identically to power-up reset.

Test Plan:
- Run with TICK_DIV=4, GAP_MS=2.
  - Push (000,3) from IDLE -> movementCommand=000 for exactly 12 cycles, then 010; done pulses once; busy high throughout.
  - Push (000,2), (001,2) -> 000 for 8 cycles, 010 for 8 cycles (gap), 001 for 8 cycles, then 010 + done.
- Push (100,1), (100,1) -> continuous 100 for 8 cycles with no 010 between them; a single done pulse.
- Fill the FIFO with 4 entries while RUN is active -> cmd_ready=0 and fifo_count=4. After the next pop, cmd_ready=1 on the following cycle. A 5th push presented during full is not accepted.
- Push (111,5), (010,0), (101,1) -> bad_cmd pulses once, the zero-duration entry is dropped, then 101 for 4 cycles (no gap since last_motion=010).
- Assert abort during RUN of (000,10) with 2 entries queued -> next cycle movementCommand=010, fifo_count=0, no done. Deassert abort and push (001,1) -> 001 appears without a gap. Then assert CPU_RESETN low mid-RUN -> outputs immediately return to reset values.
